// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator side of the 8-bit-address data memory interface.
// Takes single read/write requests from the core, drives the memory strobes,
// and returns captured read words over a valid/ready response channel.
module mem_access_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int WDATA_W  = 8,
  parameter int RDATA_W  = 16,
  parameter int RD_WAIT  = 1,
  parameter int WR_PULSE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [WDATA_W-1:0] req_wdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [RDATA_W-1:0] resp_rdata,
  output logic               wr_done,
  output logic [ADDR_W-1:0]  maddr,
  output logic               mrd,
  output logic               mwr,
  output logic [WDATA_W-1:0] mwr_data,
  input  logic [RDATA_W-1:0] mdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // The counter is loaded with (cycles - 1) so that reaching zero marks the
  // final strobe cycle; the next edge then leaves the state.
  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_PULSE - 1);

  logic [1:0] state;
  logic [3:0] cnt;

  assign req_ready = (state == IDLE);

  // Request sequencing: accept in IDLE, time the strobe, capture read data,
  // and hold the response until the core takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      wr_done    <= 1'b0;
      maddr      <= '0;
      mrd        <= 1'b0;
      mwr        <= 1'b0;
      mwr_data   <= '0;
    end else begin
      wr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            maddr <= req_addr;
            if (req_we) begin
              mwr_data <= req_wdata;
              mwr      <= 1'b1;
              cnt      <= WR_LOAD;
              state    <= WRITE;
            end else begin
              mrd   <= 1'b1;
              cnt   <= RD_LOAD;
              state <= READ;
            end
          end
        end
        WRITE: begin
          if (cnt == 4'd0) begin
            mwr     <= 1'b0;
            wr_done <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        READ: begin
          if (cnt == 4'd0) begin
            mrd        <= 1'b0;
            resp_rdata <= mdata;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: instance A uses default timing with a
// memory model, instance B uses RD_WAIT=3 / WR_PULSE=2 with directly driven mdata.
module tb_mem_access_ctrl;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] exp_rdata;
    int          exp_lat;
    int          exp_pulse;
  } vec_t;

  logic clk;
  logic rst_a, rst_b;

  logic        a_req_valid, a_req_ready, a_req_we;
  logic [7:0]  a_req_addr, a_req_wdata;
  logic        a_resp_valid, a_resp_ready;
  logic [15:0] a_resp_rdata;
  logic        a_wr_done, a_mrd, a_mwr;
  logic [7:0]  a_maddr, a_mwr_data;
  logic [15:0] a_mdata;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [7:0]  b_req_addr, b_req_wdata;
  logic        b_resp_valid, b_resp_ready;
  logic [15:0] b_resp_rdata;
  logic        b_wr_done, b_mrd, b_mwr;
  logic [7:0]  b_maddr, b_mwr_data;
  logic [15:0] b_mdata;

  int pass_count = 0;
  int total_count = 0;

  logic [15:0] rd_q[$];
  logic [15:0] wr_q[$];
  logic [15:0] mem [256];

  mem_access_ctrl dut_a (
    .clk(clk), .rst(rst_a),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_rdata(a_resp_rdata),
    .wr_done(a_wr_done), .maddr(a_maddr), .mrd(a_mrd), .mwr(a_mwr),
    .mwr_data(a_mwr_data), .mdata(a_mdata)
  );

  mem_access_ctrl #(.RD_WAIT(3), .WR_PULSE(2)) dut_b (
    .clk(clk), .rst(rst_b),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata),
    .wr_done(b_wr_done), .maddr(b_maddr), .mrd(b_mrd), .mwr(b_mwr),
    .mwr_data(b_mwr_data), .mdata(b_mdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model for instance A: preset to {A5, addr}, writes store zero-extended data.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'hA5, 8'(i)};
  end
  always @(posedge clk) begin
    if (a_mwr) mem[a_maddr] <= {8'h00, a_mwr_data};
  end
  assign a_mdata = mem[a_maddr];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                              input logic [15:0] rdata, input int lat, input int pulse);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.exp_rdata = rdata;
    v.exp_lat = lat; v.exp_pulse = pulse;
    return v;
  endfunction

  // Scoreboard for instance A: pops expected writes on wr_done and expected reads on handshake.
  always @(negedge clk) begin
    logic [15:0] exp_v;
    #1;
    if (!rst_a) begin
      check_output("strobes_exclusive", 32'(a_mrd & a_mwr), 0);
      if (a_wr_done) begin
        check_output("wr_done_expected", 32'(wr_q.size() > 0), 1);
        if (wr_q.size() > 0) begin
          exp_v = wr_q.pop_front();
          check_output("wr_done_maddr", 32'(a_maddr), 32'(exp_v[15:8]));
          check_output("wr_done_wdata", 32'(a_mwr_data), 32'(exp_v[7:0]));
        end
      end
      if (a_resp_valid && a_resp_ready) begin
        check_output("resp_expected", 32'(rd_q.size() > 0), 1);
        if (rd_q.size() > 0) begin
          exp_v = rd_q.pop_front();
          check_output("resp_rdata", 32'(a_resp_rdata), 32'(exp_v));
        end
      end
    end
  end

  task automatic apply_stimulus(input vec_t v);
    int lat, strobe, wrong, budget;
    bit done;
    a_req_valid = 1'b1; a_req_we = v.we; a_req_addr = v.addr; a_req_wdata = v.wdata;
    budget = 0;
    while (!a_req_ready && budget < 20) begin
      @(negedge clk); budget++;
    end
    check_output("req_ready", 32'(a_req_ready), 1);
    if (v.we) wr_q.push_back({v.addr, v.wdata});
    else      rd_q.push_back(v.exp_rdata);
    @(negedge clk);
    a_req_valid = 1'b0;
    check_output("maddr", 32'(a_maddr), 32'(v.addr));
    lat = 1; strobe = 0; wrong = 0; done = 1'b0;
    while (!done && lat < 20) begin
      if (v.we) begin
        strobe += int'(a_mwr); wrong += int'(a_mrd); done = a_wr_done;
      end else begin
        strobe += int'(a_mrd); wrong += int'(a_mwr); done = a_resp_valid;
      end
      if (!done) begin
        @(negedge clk); lat++;
      end
    end
    check_output("latency", 32'(lat), 32'(v.exp_lat));
    check_output("strobe_cycles", 32'(strobe), 32'(v.exp_pulse));
    check_output("other_strobe", 32'(wrong), 0);
  endtask

  task automatic b_transfer(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                            output int lat, output int strobe);
    int guard;
    b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata;
    check_output("b_req_ready", 32'(b_req_ready), 1);
    @(negedge clk);
    b_req_valid = 1'b0;
    lat = 1; strobe = 0; guard = 0;
    while (guard < 20) begin
      if (we ? b_wr_done : b_resp_valid) break;
      strobe += we ? int'(b_mwr) : int'(b_mrd);
      if (!we) b_mdata = (lat == 3) ? 16'hBEEF : 16'hDEAD;
      @(negedge clk); lat++; guard++;
    end
    b_mdata = 16'hDEAD;
  endtask

  // Hard stop in case anything hangs.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  // Main stimulus: table, back-to-back stream, backpressure, then instance B corner cases.
  initial begin
    vec_t tbl[9];
    vec_t items[6];
    int lat, strobe, k, cyc, last_acc, cnt_valid;

    tbl[0] = mk(1'b1, 8'h00, 8'h00, 16'h0000, 2, 1);
    tbl[1] = mk(1'b1, 8'h01, 8'h01, 16'h0000, 2, 1);
    tbl[2] = mk(1'b0, 8'h01, 8'h00, 16'h0001, 2, 1);
    tbl[3] = mk(1'b0, 8'h00, 8'h00, 16'h0000, 2, 1);
    tbl[4] = mk(1'b1, 8'h5A, 8'hC3, 16'h0000, 2, 1);
    tbl[5] = mk(1'b0, 8'h5A, 8'h00, 16'h00C3, 2, 1);
    tbl[6] = mk(1'b0, 8'h10, 8'h00, 16'hA510, 2, 1);
    tbl[7] = mk(1'b1, 8'hFF, 8'h7E, 16'h0000, 2, 1);
    tbl[8] = mk(1'b0, 8'hFF, 8'h00, 16'h007E, 2, 1);

    items[0] = mk(1'b1, 8'h40, 8'h11, 16'h0000, 0, 0);
    items[1] = mk(1'b0, 8'h40, 8'h00, 16'h0011, 0, 0);
    items[2] = mk(1'b1, 8'h41, 8'h22, 16'h0000, 0, 0);
    items[3] = mk(1'b0, 8'h41, 8'h00, 16'h0022, 0, 0);
    items[4] = mk(1'b1, 8'h40, 8'h33, 16'h0000, 0, 0);
    items[5] = mk(1'b0, 8'h40, 8'h00, 16'h0033, 0, 0);

    rst_a = 1'b1; rst_b = 1'b1;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = 8'h00; a_req_wdata = 8'h00;
    a_resp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 8'h00; b_req_wdata = 8'h00;
    b_resp_ready = 1'b1; b_mdata = 16'hDEAD;
    repeat (2) @(negedge clk);

    check_output("rst_req_ready", 32'(a_req_ready), 1);
    check_output("rst_resp_valid", 32'(a_resp_valid), 0);
    check_output("rst_resp_rdata", 32'(a_resp_rdata), 0);
    check_output("rst_wr_done", 32'(a_wr_done), 0);
    check_output("rst_maddr", 32'(a_maddr), 0);
    check_output("rst_mrd", 32'(a_mrd), 0);
    check_output("rst_mwr", 32'(a_mwr), 0);
    check_output("rst_mwr_data", 32'(a_mwr_data), 0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) apply_stimulus(tbl[i]);
    @(negedge clk);

    // Continuous stream alternating write/read with resp_ready held high.
    k = 0; cyc = 0; last_acc = 0;
    a_req_valid = 1'b1; a_req_we = items[0].we;
    a_req_addr = items[0].addr; a_req_wdata = items[0].wdata;
    while (k < 6 && cyc < 60) begin
      if (a_req_ready) begin
        if (k > 0) check_output("b2b_period", 32'(cyc - last_acc), items[k-1].we ? 2 : 3);
        if (items[k].we) wr_q.push_back({items[k].addr, items[k].wdata});
        else             rd_q.push_back(items[k].exp_rdata);
        last_acc = cyc; k++;
        @(negedge clk); cyc++;
        if (k < 6) begin
          a_req_we = items[k].we; a_req_addr = items[k].addr; a_req_wdata = items[k].wdata;
        end else begin
          a_req_valid = 1'b0;
        end
      end else begin
        @(negedge clk); cyc++;
      end
    end
    check_output("b2b_accepted", 32'(k), 6);
    repeat (4) @(negedge clk);
    check_output("b2b_rd_q_drained", 32'(rd_q.size()), 0);
    check_output("b2b_wr_q_drained", 32'(wr_q.size()), 0);

    // Backpressure: response held while resp_ready is low, pending write waits.
    a_resp_ready = 1'b0;
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 8'hA5; a_req_wdata = 8'h00;
    check_output("bp_req_ready", 32'(a_req_ready), 1);
    rd_q.push_back(16'hA5A5);
    @(negedge clk);
    a_req_we = 1'b1; a_req_addr = 8'h33; a_req_wdata = 8'h44;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_output("bp_resp_valid", 32'(a_resp_valid), 1);
      check_output("bp_resp_rdata", 32'(a_resp_rdata), 32'h0000A5A5);
      check_output("bp_req_ready_low", 32'(a_req_ready), 0);
      check_output("bp_mwr_low", 32'(a_mwr), 0);
      @(negedge clk);
    end
    check_output("bp_still_valid", 32'(a_resp_valid), 1);
    a_resp_ready = 1'b1;
    @(negedge clk);
    check_output("bp_idle_ready", 32'(a_req_ready), 1);
    check_output("bp_resp_dropped", 32'(a_resp_valid), 0);
    check_output("bp_not_yet_accepted", 32'(a_mwr), 0);
    wr_q.push_back({8'h33, 8'h44});
    @(negedge clk);
    a_req_valid = 1'b0;
    check_output("bp_write_mwr", 32'(a_mwr), 1);
    check_output("bp_write_maddr", 32'(a_maddr), 32'h33);
    repeat (3) @(negedge clk);
    check_output("bp_rd_q_drained", 32'(rd_q.size()), 0);
    check_output("bp_wr_q_drained", 32'(wr_q.size()), 0);

    // Instance B: longer write pulse.
    b_transfer(1'b1, 8'h20, 8'h99, lat, strobe);
    check_output("b_write_latency", 32'(lat), 3);
    check_output("b_write_pulse", 32'(strobe), 2);
    check_output("b_write_mwr_data", 32'(b_mwr_data), 32'h99);
    @(negedge clk);

    // Instance B: mdata only valid in the last mrd cycle.
    b_transfer(1'b0, 8'h21, 8'h00, lat, strobe);
    check_output("b_read_latency", 32'(lat), 4);
    check_output("b_read_mrd_cycles", 32'(strobe), 3);
    check_output("b_read_rdata", 32'(b_resp_rdata), 32'h0000BEEF);
    @(negedge clk);
    check_output("b_read_resp_done", 32'(b_resp_valid), 0);

    // Instance B: reset in the second mrd cycle discards the read.
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 8'h77; b_mdata = 16'h1234;
    check_output("b_rst_req_ready", 32'(b_req_ready), 1);
    @(negedge clk);
    b_req_valid = 1'b0;
    check_output("b_rst_mrd1", 32'(b_mrd), 1);
    @(negedge clk);
    check_output("b_rst_mrd2", 32'(b_mrd), 1);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    check_output("b_rst_mrd", 32'(b_mrd), 0);
    check_output("b_rst_resp_valid", 32'(b_resp_valid), 0);
    check_output("b_rst_req_ready_hi", 32'(b_req_ready), 1);
    check_output("b_rst_maddr", 32'(b_maddr), 0);
    check_output("b_rst_mwr_data", 32'(b_mwr_data), 0);
    check_output("b_rst_resp_rdata", 32'(b_resp_rdata), 0);
    check_output("b_rst_wr_done", 32'(b_wr_done), 0);
    check_output("b_rst_mwr", 32'(b_mwr), 0);
    cnt_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cnt_valid += int'(b_resp_valid) + int'(b_mrd);
    end
    check_output("b_rst_no_response", 32'(cnt_valid), 0);
    b_mdata = 16'hDEAD;

    $display("[TB] %0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
